// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register pending-write scoreboard.
// Two combinational read ports with writeback bypass, one synchronous write
// port, optional hardwired-zero register 0, and a registered busy count.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            busy1,
    output logic            busy2,
    input  logic            WE3,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            issue,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             zero_en;
    logic             wr_en;
    logic             iss_en;

    assign zero_en = (ZERO_REG != 0);
    assign wr_en   = WE3 && !(zero_en && (A3 == '0));
    assign iss_en  = issue && !(zero_en && (issue_rd == '0));

    // Register array: reset clears every entry, writes to register 0 dropped when hardwired
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[A3] <= WD3;
        end
    end

    // Next busy vector: flush clears all; otherwise writeback clears, then issue sets (issue wins)
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_en) begin
                busy_d[A3] = 1'b0;
            end
            if (iss_en) begin
                busy_d[issue_rd] = 1'b1;
            end
        end
    end

    // Population count of the next busy vector so the count tracks the bits on the same edge
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    // Scoreboard state and its count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    // Read port 1: zero register, then bypass of the in-flight writeback, then storage
    always_comb begin
        RD1   = '0;
        busy1 = 1'b0;
        if (!rst) begin
            RD1   = '0;
            busy1 = 1'b0;
        end else if (zero_en && (A1 == '0)) begin
            RD1   = '0;
            busy1 = 1'b0;
        end else if (WE3 && (A3 == A1)) begin
            RD1   = WD3;
            busy1 = 1'b0;
        end else begin
            RD1   = regs_q[A1];
            busy1 = busy_q[A1];
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        RD2   = '0;
        busy2 = 1'b0;
        if (!rst) begin
            RD2   = '0;
            busy2 = 1'b0;
        end else if (zero_en && (A2 == '0)) begin
            RD2   = '0;
            busy2 = 1'b0;
        end else if (WE3 && (A3 == A2)) begin
            RD2   = WD3;
            busy2 = 1'b0;
        end else begin
            RD2   = regs_q[A2];
            busy2 = busy_q[A2];
        end
    end

endmodule
